// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants for the PWM peripheral
package pwm_pkg;

    localparam int CLK_DIV_DEFAULT = 13;
    localparam int CNT_W_DEFAULT   = 8;
    localparam logic [7:0] DUTY_FULL = 8'hFF;
    localparam int NUM_CH          = 16;

endpackage : pwm_pkg

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - divides clk down to a one-cycle PWM tick
module pwm_prescaler #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // A single-cycle divider still needs a one-bit register to stay legal.
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // Tick on the last count, then fold back to zero.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + PW'(1);
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : pwm_prescaler

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-channel PWM with shared counter and shadowed duty
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        en_reg_out_7_0,
    input  logic [7:0]        en_reg_out_15_8,
    input  logic [7:0]        en_reg_pwm_7_0,
    input  logic [7:0]        en_reg_pwm_15_8,
    input  logic [7:0]        pwm_duty_cycle,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    // Compare width covers both the counter and the 8-bit duty value.
    localparam int CMP_W = (CNT_W > 8) ? CNT_W : 8;

    logic              tick;
    logic              wrap;
    logic              pwm_sig;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [7:0]        shadow_q;
    logic [7:0]        shadow_d;
    logic              period_start_q;
    logic              period_start_d;
    logic [NUM_CH-1:0] out_q;
    logic [NUM_CH-1:0] out_d;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [CMP_W-1:0]  cmp_cnt;
    logic [CMP_W-1:0]  cmp_shadow;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Counter advance, period boundary, duty reload and per-channel output select.
    always_comb begin
        wrap           = tick && (cnt_q == {CNT_W{1'b1}});
        cnt_d          = tick ? cnt_q + CNT_W'(1) : cnt_q;
        period_start_d = wrap;
        // Duty only changes at the wrap so a period is never cut short or stretched.
        shadow_d       = wrap ? pwm_duty_cycle : shadow_q;
        cmp_cnt        = CMP_W'(cnt_q);
        cmp_shadow     = CMP_W'(shadow_q);
        pwm_sig        = (shadow_q == DUTY_FULL) || (cmp_cnt < cmp_shadow);
        en_out         = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm         = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        out_d          = en_out & (~en_pwm | {NUM_CH{pwm_sig}});
    end

    // All state registers; outputs are registered so no input reaches out combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            shadow_q       <= '0;
            period_start_q <= 1'b0;
            out_q          <= '0;
        end else begin
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            period_start_q <= period_start_d;
            out_q          <= out_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule : pwm_peripheral

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter CLK_DIV, default 13, system-clock cycles per PWM tick (>=1).
REQ-002 SHALL have parameter CNT_W, default 8, PWM counter width; one period = 2^CNT_W ticks.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en_reg_out_7_0  input  8  output enable, channels 7..0.
REQ-007 en_reg_out_15_8  input  8  output enable, channels 15..8.
REQ-008 en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0.
REQ-009 en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8.
REQ-010 pwm_duty_cycle  input  8  shared duty value, 0x00 = 0 %, 0xFF = 100 %.
REQ-011 out  output  16  registered channel outputs.
REQ-012 period_start  output  1  one-cycle strobe when PWM counter wraps to 0.

Function
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and assert an internal tick for one clk cycle when it reaches CLK_DIV-1, then return to 0.
REQ-014 PWM counter (CNT_W bits) SHALL increment only on tick, wrapping 255 -> 0 modulo 2^CNT_W.
REQ-015 period_start SHALL pulse high for exactly one clk cycle on the tick that wraps the counter to 0.
REQ-016 Duty shadow register SHALL load pwm_duty_cycle only on the period_start cycle; mid-period duty changes SHALL take effect at the next period boundary (glitch-free).
REQ-017 pwm_sig SHALL be 1 when shadow == 0xFF, else 1 when counter < shadow, else 0.
REQ-018 Duty 0x00 SHALL give constant 0; 0xFF constant 1; 0x80 exactly 128 of 256 ticks high.
REQ-019 Per channel i: out[i] next = 0 if enable bit i is 0; 1 if enable=1 and pwm-mode=0; pwm_sig if enable=1 and pwm-mode=1.
REQ-020 Enable and mode inputs SHALL take effect with 1-clk latency (not deferred to the period boundary).
REQ-021 out SHALL lag the counter/shadow state by exactly one clk cycle.
REQ-022 All 16 PWM channels SHALL share one counter and one shadow; channels SHALL be phase-aligned.
REQ-023 With CLK_DIV=1 tick SHALL be asserted every cycle.

Reset
REQ-024 While rst=1: prescaler, counter, duty shadow, out, period_start SHALL all be 0.
REQ-025 On first cycle after rst deasserts, prescaler SHALL start at 0; the first period_start SHALL occur after 256*CLK_DIV cycles.
REQ-026 Reset asserted mid-period SHALL abort the period immediately; no partial pulse SHALL follow reset release until duty is reloaded at the next period_start.

Structure
REQ-027 Shared package pwm_pkg SHALL hold CLK_DIV_DEFAULT (13), CNT_W_DEFAULT (8), DUTY_FULL (8'hFF), NUM_CH (16).
REQ-028 Prescaler SHALL be a sub-module pwm_prescaler (ports clk, rst, tick; parameter CLK_DIV).
REQ-029 No combinational path SHALL exist from any input to out.

Verification (CLK_DIV=13 unless noted)
REQ-030 Reset: rst=1 for 5 cycles with all inputs 0xFF -> out=0x0000, period_start=0 throughout.
REQ-031 Static: en_out=0xFFFF, en_pwm=0x0000 -> out=0xFFFF one cycle after reset release; en_out=0x00FF -> out=0x00FF next cycle.
REQ-032 Duty 0x80, en_out=en_pwm=0x0001 -> out[0] high 128*13 cycles, low 128*13 cycles per 3328-cycle period.
REQ-033 Boundaries: duty 0x00 -> out[0] never high; duty 0xFF -> out[0] constant 1 across 3 periods.
REQ-034 Glitch-free: duty 0x40 -> 0xC0 written mid-period -> current period high 64 ticks, next period high 192 ticks.
REQ-035 CLK_DIV=1, duty 0x01 -> out[0] high exactly 1 cycle every 256 cycles; period_start every 256 cycles.
